// File: rtl/program_loader.sv
// Boot loader: assembles little-endian halfwords from a host byte stream, writes them to
// instruction memory and releases the core. Optional checksum byte: PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int unsigned WORD           = 32,
  parameter int unsigned HALF_WORD      = 16,
  parameter int unsigned MAX_HALF_WORDS = 256,
  parameter int unsigned BASE_ADDR      = 0,
  parameter int unsigned ADDR_STEP      = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 byte_valid_i,
  input  logic [7:0]           byte_i,
  output logic                 byte_ready_o,
  output logic                 program_mem_write_en_o,
  output logic [HALF_WORD-1:0] instruction_o,
  output logic [WORD-1:0]      instruction_addr_o,
  output logic                 cpu_reset_o,
  output logic                 done_o,
  output logic                 error_o
);

  localparam logic [2:0] LEN_LO  = 3'd0;
  localparam logic [2:0] LEN_HI  = 3'd1;
  localparam logic [2:0] DATA_LO = 3'd2;
  localparam logic [2:0] DATA_HI = 3'd3;
  localparam logic [2:0] WRITE   = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;
  localparam logic [2:0] ERROR   = 3'd6;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam logic [2:0] CHECK   = 3'd7;
`endif

  logic [2:0]           r_state;
  logic [15:0]          r_len;
  logic [15:0]          r_index;
  logic [7:0]           r_lo;
  logic [HALF_WORD-1:0] r_instr;
  logic [WORD-1:0]      r_addr;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]           r_csum;
`endif

  logic                 w_hs;
  logic [15:0]          w_len;
  logic [15:0]          w_index_nxt;
  logic [WORD-1:0]      w_addr;

  always_comb begin
    byte_ready_o = 1'b0;
    case (r_state)
      LEN_LO, LEN_HI, DATA_LO, DATA_HI: byte_ready_o = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CHECK:                            byte_ready_o = 1'b1;
`endif
      default:                          byte_ready_o = 1'b0;
    endcase
  end

  assign w_hs        = byte_valid_i & byte_ready_o;
  assign w_len       = {byte_i, r_len[7:0]};
  assign w_index_nxt = r_index + 16'd1;
  assign w_addr      = WORD'(BASE_ADDR) + WORD'(r_index) * WORD'(ADDR_STEP);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= LEN_LO;
      r_len   <= '0;
      r_index <= '0;
      r_lo    <= '0;
      r_instr <= '0;
      r_addr  <= WORD'(BASE_ADDR);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      r_csum  <= '0;
`endif
    end else begin
      case (r_state)
        LEN_LO: if (w_hs) begin
          r_len[7:0] <= byte_i;
          r_state    <= LEN_HI;
        end
        LEN_HI: if (w_hs) begin
          r_len[15:8] <= byte_i;
          if (w_len == 16'd0 || w_len > 16'(MAX_HALF_WORDS)) r_state <= ERROR;
          else                                                r_state <= DATA_LO;
        end
        DATA_LO: if (w_hs) begin
          r_lo    <= byte_i;
          r_state <= DATA_HI;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          r_csum  <= r_csum ^ byte_i;
`endif
        end
        // Instruction and address update together so both hold steady outside WRITE.
        DATA_HI: if (w_hs) begin
          r_instr <= HALF_WORD'({byte_i, r_lo});
          r_addr  <= w_addr;
          r_state <= WRITE;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          r_csum  <= r_csum ^ byte_i;
`endif
        end
        WRITE: begin
          r_index <= w_index_nxt;
          if (w_index_nxt == r_len) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            r_state <= CHECK;
`else
            r_state <= DONE;
`endif
          end else begin
            r_state <= DATA_LO;
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        CHECK: if (w_hs) begin
          r_state <= (byte_i == r_csum) ? DONE : ERROR;
        end
`endif
        default: r_state <= r_state;
      endcase
    end
  end

  assign program_mem_write_en_o = (r_state == WRITE);
  assign instruction_o          = r_instr;
  assign instruction_addr_o     = r_addr;
  assign cpu_reset_o            = (r_state != DONE);
  assign done_o                 = (r_state == DONE);
  assign error_o                = (r_state == ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader; also covers PROGRAM_LOADER_CHECKSUM_EN builds.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        byte_valid_i = 1'b0;
  logic [7:0]  byte_i = 8'h00;
  logic        byte_ready_o;
  logic        program_mem_write_en_o;
  logic [15:0] instruction_o;
  logic [31:0] instruction_addr_o;
  logic        cpu_reset_o;
  logic        done_o;
  logic        error_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cyc = -1;
  logic [15:0] wr_data[$];
  logic [31:0] wr_addr[$];
  int          wr_cyc[$];

  program_loader dut (
    .clk_i                  (clk),
    .reset_i                (reset_i),
    .byte_valid_i           (byte_valid_i),
    .byte_i                 (byte_i),
    .byte_ready_o           (byte_ready_o),
    .program_mem_write_en_o (program_mem_write_en_o),
    .instruction_o          (instruction_o),
    .instruction_addr_o     (instruction_addr_o),
    .cpu_reset_o            (cpu_reset_o),
    .done_o                 (done_o),
    .error_o                (error_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory-side monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (program_mem_write_en_o) begin
      wr_data.push_back(instruction_o);
      wr_addr.push_back(instruction_addr_o);
      wr_cyc.push_back(cyc);
    end
    if (done_o && done_cyc < 0) done_cyc = cyc;
  end

  task automatic do_reset();
    @(negedge clk);
    reset_i = 1'b1;
    byte_valid_i = 1'b0;
    @(negedge clk);
    reset_i = 1'b0;
    wr_data.delete();
    wr_addr.delete();
    wr_cyc.delete();
    done_cyc = -1;
  endtask

  // Called at a negedge; returns at the negedge after the byte is consumed.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_valid_i = 1'b1;
    byte_i = b;
    while (!byte_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL send_timeout byte=%02h ready stayed 0, required 1", b);
    end
    @(negedge clk);
  endtask

  task automatic stream_three(input bit toggle);
    logic [7:0] s[8];
    s = '{8'h03, 8'h00, 8'h01, 8'h20, 8'h02, 8'h21, 8'h03, 8'h22};
    for (int i = 0; i < 8; i++) begin
      // Keep valid high across WRITE before each new low byte; idle a cycle otherwise.
      if (toggle && !(i >= 4 && i % 2 == 0)) begin
        byte_valid_i = 1'b0;
        @(negedge clk);
      end
      send_byte(s[i]);
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(8'h23);
`endif
    byte_valid_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (byte_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", byte_ready_o); end
    total++; if (cpu_reset_o !== 1'b1) begin bad++; $display("FAIL reset_cpu_reset got=%b exp=1", cpu_reset_o); end
    total++; if (program_mem_write_en_o !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", program_mem_write_en_o); end
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done_o); end
    total++; if (error_o !== 1'b0) begin bad++; $display("FAIL reset_error got=%b exp=0", error_o); end
    total++; if (instruction_addr_o !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", instruction_addr_o); end
    total++; if (instruction_o !== 16'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", instruction_o); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ed[3];
    ed = '{16'h2001, 16'h2102, 16'h2203};
    do_reset();
    stream_three(1'b0);
    total++; if (wr_data.size() !== 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", wr_data.size()); end
    for (int i = 0; i < 3 && i < wr_data.size(); i++) begin
      total++; if (wr_data[i] !== ed[i]) begin bad++; $display("FAIL b2b_data%0d got=%h exp=%h", i, wr_data[i], ed[i]); end
      total++; if (wr_addr[i] !== 32'(2 * i)) begin bad++; $display("FAIL b2b_addr%0d got=%h exp=%h", i, wr_addr[i], 2 * i); end
    end
`ifndef PROGRAM_LOADER_CHECKSUM_EN
    if (wr_cyc.size() == 3) begin
      total++; if (done_cyc !== wr_cyc[2] + 1) begin bad++; $display("FAIL b2b_done_timing got=%0d exp=%0d", done_cyc, wr_cyc[2] + 1); end
    end
    total++; if (byte_ready_o !== 1'b0) begin bad++; $display("FAIL b2b_ready_in_done got=%b exp=0", byte_ready_o); end
`endif
    total++; if (done_o !== 1'b1) begin bad++; $display("FAIL b2b_done got=%b exp=1", done_o); end
    total++; if (cpu_reset_o !== 1'b0) begin bad++; $display("FAIL b2b_cpu_reset got=%b exp=0", cpu_reset_o); end
  endtask

  task automatic test_toggle();
    logic [15:0] ed[3];
    ed = '{16'h2001, 16'h2102, 16'h2203};
    do_reset();
    stream_three(1'b1);
    total++; if (wr_data.size() !== 3) begin bad++; $display("FAIL tog_count got=%0d exp=3", wr_data.size()); end
    for (int i = 0; i < 3 && i < wr_data.size(); i++) begin
      total++; if (wr_data[i] !== ed[i]) begin bad++; $display("FAIL tog_data%0d got=%h exp=%h", i, wr_data[i], ed[i]); end
      total++; if (wr_addr[i] !== 32'(2 * i)) begin bad++; $display("FAIL tog_addr%0d got=%h exp=%h", i, wr_addr[i], 2 * i); end
    end
    total++; if (done_o !== 1'b1) begin bad++; $display("FAIL tog_done got=%b exp=1", done_o); end
  endtask

  task automatic test_bad_len(input logic [7:0] lo, input logic [7:0] hi);
    do_reset();
    send_byte(lo);
    send_byte(hi);
    byte_valid_i = 1'b0;
    total++; if (error_o !== 1'b1) begin bad++; $display("FAIL badlen_%02h%02h_error got=%b exp=1", hi, lo, error_o); end
    total++; if (byte_ready_o !== 1'b0) begin bad++; $display("FAIL badlen_%02h%02h_ready got=%b exp=0", hi, lo, byte_ready_o); end
    total++; if (cpu_reset_o !== 1'b1) begin bad++; $display("FAIL badlen_%02h%02h_cpu_reset got=%b exp=1", hi, lo, cpu_reset_o); end
    repeat (3) @(negedge clk);
    total++; if (wr_data.size() !== 0) begin bad++; $display("FAIL badlen_%02h%02h_writes got=%0d exp=0", hi, lo, wr_data.size()); end
  endtask

  task automatic test_max_len();
    int errs = 0;
    do_reset();
    send_byte(8'h00);
    send_byte(8'h01);
    for (int i = 0; i < 256; i++) begin
      send_byte(8'(i));
      send_byte(~8'(i));
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(8'h00);  // each pair XORs to FF; 256 pairs cancel
`endif
    byte_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (wr_data.size() !== 256) begin bad++; $display("FAIL max_count got=%0d exp=256", wr_data.size()); end
    for (int i = 0; i < wr_data.size() && i < 256; i++) begin
      if (wr_addr[i] !== 32'(2 * i) || wr_data[i] !== {~8'(i), 8'(i)}) errs++;
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL max_contents got=%0d bad entries exp=0", errs); end
    if (wr_addr.size() == 256) begin
      total++; if (wr_addr[255] !== 32'h1FE) begin bad++; $display("FAIL max_last_addr got=%h exp=1fe", wr_addr[255]); end
    end
    total++; if (done_o !== 1'b1) begin bad++; $display("FAIL max_done got=%b exp=1", done_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    byte_valid_i = 1'b0;
    @(negedge clk);
    total++; if (wr_data.size() !== 1) begin bad++; $display("FAIL mid_first_count got=%0d exp=1", wr_data.size()); end
    do_reset();
    total++; if (cpu_reset_o !== 1'b1) begin bad++; $display("FAIL mid_cpu_reset got=%b exp=1", cpu_reset_o); end
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(8'h11);
`endif
    byte_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (wr_data.size() !== 1) begin bad++; $display("FAIL mid_count got=%0d exp=1", wr_data.size()); end
    if (wr_data.size() >= 1) begin
      total++; if (wr_data[0] !== 16'hBBAA) begin bad++; $display("FAIL mid_data got=%h exp=bbaa", wr_data[0]); end
      total++; if (wr_addr[0] !== 32'h0) begin bad++; $display("FAIL mid_addr got=%h exp=0", wr_addr[0]); end
    end
    total++; if (done_o !== 1'b1) begin bad++; $display("FAIL mid_done got=%b exp=1", done_o); end
  endtask

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  task automatic test_checksum(input logic [7:0] csum, input bit good);
    do_reset();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h34);
    send_byte(8'h12);
    send_byte(csum);
    byte_valid_i = 1'b0;
    @(negedge clk);
    total++; if (wr_data.size() !== 1) begin bad++; $display("FAIL csum_%02h_writes got=%0d exp=1", csum, wr_data.size()); end
    total++; if (done_o !== good) begin bad++; $display("FAIL csum_%02h_done got=%b exp=%b", csum, done_o, good); end
    total++; if (error_o !== !good) begin bad++; $display("FAIL csum_%02h_error got=%b exp=%b", csum, error_o, !good); end
    total++; if (cpu_reset_o !== !good) begin bad++; $display("FAIL csum_%02h_cpu_reset got=%b exp=%b", csum, cpu_reset_o, !good); end
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_toggle();
    test_bad_len(8'h00, 8'h00);
    test_bad_len(8'h01, 8'h01);
    test_max_len();
    test_reset_mid();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    test_checksum(8'h26, 1'b1);
    test_checksum(8'h27, 1'b0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time stage directly upstream of the CPU core.
- Accepts a byte stream from a host interface and assembles little-endian 16-bit Thumb instructions.
- Drives the core's instruction-memory write port (program_mem_write_en_i, instruction_i, instruction_addr_i).
- Holds the core in reset until the whole image is written, then releases it.

Parameters:
- WORD, 32, width of instruction_addr_o.
- HALF_WORD, 16, instruction width.
- MAX_HALF_WORDS, 256, largest accepted image length in halfwords (instruction memory depth).
- BASE_ADDR, 0, address of the first halfword.
- ADDR_STEP, 2, address increment per halfword (byte-addressed PC).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- byte_valid_i  in  1  host byte valid.
- byte_i  in  8  host byte.
- byte_ready_o  out  1  loader accepts byte; handshake = byte_valid_i & byte_ready_o on a rising edge.
- program_mem_write_en_o  out  1  instruction-memory write strobe.
- instruction_o  out  HALF_WORD  assembled instruction.
- instruction_addr_o  out  WORD  write address.
- cpu_reset_o  out  1  reset to the CPU core; high until load completes.
- done_o  out  1  image loaded; core running.
- error_o  out  1  load aborted.

Behaviour:
- Interface (already decided): one clock, clk_i; reset_i is synchronous and active-high.
- All outputs are registered or decoded from state registers only; no combinational path from byte_valid_i to any output.
- Reset values:
  - state = LEN_LO, byte_ready_o = 1, program_mem_write_en_o = 0, instruction_o = 0.
  - instruction_addr_o = BASE_ADDR, cpu_reset_o = 1, done_o = 0, error_o = 0.
  - Halfword index = 0, length register = 0.
- Stream format: len[7:0], len[15:8], then len × {instr[7:0], instr[15:8]}.
- FSM; byte_ready_o = 1 only in LEN_LO, LEN_HI, DATA_LO, DATA_HI:
  - LEN_LO: on handshake latch len[7:0] -> LEN_HI.
  - LEN_HI: on handshake latch len[15:8].
    - If len == 0 or len > MAX_HALF_WORDS -> ERROR.
    - Otherwise -> DATA_LO.
  - DATA_LO: on handshake latch instruction_o[7:0] -> DATA_HI.
  - DATA_HI: on handshake latch instruction_o[15:8] -> WRITE.
  - WRITE (exactly 1 cycle):
    - program_mem_write_en_o = 1; instruction_addr_o = BASE_ADDR + index*ADDR_STEP, computed in WORD bits with wrap.
    - Index increments on exit.
    - If incremented index == len -> DONE (CHECK when the optional feature is enabled); else -> DATA_LO.
  - DONE: cpu_reset_o = 0, done_o = 1; terminal until reset_i.
  - ERROR: error_o = 1, cpu_reset_o = 1; terminal until reset_i.
- Latency: the write strobe is high on the cycle immediately after the DATA_HI handshake.
- Minimum 3 cycles per halfword (DATA_LO, DATA_HI, WRITE).
- Bytes presented while byte_ready_o = 0 are not consumed; the host must hold them.
- instruction_o and instruction_addr_o stay stable outside WRITE.
- cpu_reset_o falls on the cycle after the last WRITE, together with done_o rising; never earlier.
- Reset mid-load: next cycle returns to LEN_LO with the index cleared and cpu_reset_o = 1.
  - A write in progress that cycle is suppressed; the next load starts again at BASE_ADDR.
- reset_i has priority over every handshake in the same cycle.
- Length exactly MAX_HALF_WORDS is accepted; the last write goes to BASE_ADDR + (MAX_HALF_WORDS-1)*ADDR_STEP.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- When defined:
  - The loader keeps a running 8-bit XOR of all data bytes (not the length bytes), cleared on reset.
  - After the last WRITE, the FSM enters CHECK (byte_ready_o = 1) and accepts one checksum byte.
  - Match -> DONE; mismatch -> ERROR, with the core kept in reset.
  - Writes already performed are not undone.
- When undefined: no CHECK state; the last WRITE goes directly to DONE.

Test Plan:
- Reset with byte_valid_i = 0 -> byte_ready_o = 1, cpu_reset_o = 1, program_mem_write_en_o = 0, done_o = 0, error_o = 0, instruction_addr_o = 0.
- Bytes 03 00 01 20 02 21 03 22 streamed back-to-back -> three single-cycle strobes:
  - 0x2001 @0x0, 0x2102 @0x2, 0x2203 @0x4.
  - cpu_reset_o falls and done_o rises the cycle after the third strobe.
- Same stream with byte_valid_i toggled 1/0 each cycle, and valid held high during WRITE -> identical writes; no byte consumed while byte_ready_o = 0.
- Header 00 00 -> error_o = 1 after the LEN_HI handshake, byte_ready_o = 0, no strobe.
- Header 01 01 (257 > 256) -> error_o = 1, no strobe.
- Header 00 01 (256) -> 256 strobes, last @0x1FE, then done_o = 1.
- Header 02 00 and one halfword written, then reset_i pulsed for 1 cycle, then 01 00 AA BB -> single write 0xBBAA @0x0, done_o = 1.
- With PROGRAM_LOADER_CHECKSUM_EN, stream 01 00 34 12:
  - Checksum byte 26 -> done_o = 1.
  - Checksum byte 27 -> error_o = 1, cpu_reset_o stays 1.
